// File: rtl/sm83_mcycle_seq_if.sv
// Signal bundle between the sm83 core muxing/decoder and the M-cycle sequencer.
// The sequencer acts as the slave: decode inputs in, cycle strobes out.
interface sm83_mcycle_seq_if;
    // Flow control: there is no valid/ready pair. i_stall acts as an inverted ready
    // for the whole sequencer: while it is 1, nothing advances and the decode
    // inputs are not consumed.
    logic       i_stall;
    logic [2:0] i_dec_exec;
    logic       i_dec_prefix;
    logic       i_dec_halt;
    logic       i_dec_ei;
    logic       i_dec_di;
    logic       i_dec_reti;
    logic       i_cc_fail;
    logic       i_irq_pending;
    logic       o_fetch_cycle;
    logic       o_prefix_cycle;
    logic       o_execute_cycle;
    logic [2:0] o_exec_idx;
    logic       o_isr_cycle;
    logic [2:0] o_isr_step;
    logic       o_isr_ack;
    logic       o_halted;
    logic       o_ime;
    logic       o_pc_inhibit;
    logic [2:0] state_dbg;

    modport master (
        output i_stall, i_dec_exec, i_dec_prefix, i_dec_halt, i_dec_ei, i_dec_di,
               i_dec_reti, i_cc_fail, i_irq_pending,
        input  o_fetch_cycle, o_prefix_cycle, o_execute_cycle, o_exec_idx, o_isr_cycle,
               o_isr_step, o_isr_ack, o_halted, o_ime, o_pc_inhibit, state_dbg
    );

    modport slave (
        input  i_stall, i_dec_exec, i_dec_prefix, i_dec_halt, i_dec_ei, i_dec_di,
               i_dec_reti, i_cc_fail, i_irq_pending,
        output o_fetch_cycle, o_prefix_cycle, o_execute_cycle, o_exec_idx, o_isr_cycle,
               o_isr_step, o_isr_ack, o_halted, o_ime, o_pc_inhibit, state_dbg
    );
endinterface

// File: rtl/sm83_mcycle_seq.sv
// sm83 M-cycle sequencer: fetch/prefix/execute/halt/interrupt dispatch plus IME.
// Optional macro SM83_HALT_BUG_EN enables the HALT-bug PC inhibit on the next fetch.
module sm83_mcycle_seq #(
    parameter int MAX_EXEC   = 6,
    parameter int ISR_CYCLES = 5
) (
    input logic clk,
    input logic rst_n,
    sm83_mcycle_seq_if.slave bus
);

    typedef enum logic [2:0] {
        ST_RST    = 3'd0,
        ST_FETCH  = 3'd1,
        ST_PREFIX = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4,
        ST_ISR    = 3'd5
    } state_t;

    localparam logic [2:0] MAX_LEN  = 3'(MAX_EXEC);
    localparam logic [2:0] ISR_LAST = 3'(ISR_CYCLES - 1);

    state_t     state, state_n;
    logic [2:0] len, len_n;
    logic [2:0] idx, idx_n;
    logic [2:0] step, step_n;
    logic       ime, ime_n;
    logic       ei_arm, ei_arm_n;
    logic       ei_flag, ei_flag_n;
    logic       di_flag, di_flag_n;
    logic       reti_flag, reti_flag_n;
    logic       pc_inh, pc_inh_n;

    logic [2:0] dec_len;
    logic       ei_f, di_f, reti_f, take, end_instr;

    assign dec_len = (bus.i_dec_exec > MAX_LEN) ? MAX_LEN : bus.i_dec_exec;

    // A zero-length instruction ends in its own FETCH, before its flags are latched.
    always_comb begin
        ei_f   = (state == ST_FETCH) ? bus.i_dec_ei   : ei_flag;
        di_f   = (state == ST_FETCH) ? bus.i_dec_di   : di_flag;
        reti_f = (state == ST_FETCH) ? bus.i_dec_reti : reti_flag;
        take   = (ime | ei_arm) & bus.i_irq_pending & ~di_f;
    end

    always_comb begin
        state_n     = state;
        len_n       = len;
        idx_n       = idx;
        step_n      = step;
        ime_n       = ime;
        ei_arm_n    = ei_arm;
        ei_flag_n   = ei_flag;
        di_flag_n   = di_flag;
        reti_flag_n = reti_flag;
        pc_inh_n    = 1'b0;
        end_instr   = 1'b0;
        case (state)
            ST_RST: state_n = ST_FETCH;
            ST_FETCH: begin
                len_n       = dec_len;
                ei_flag_n   = bus.i_dec_ei;
                di_flag_n   = bus.i_dec_di;
                reti_flag_n = bus.i_dec_reti;
                if (bus.i_dec_prefix) begin
                    state_n = ST_PREFIX;
                end else if (bus.i_dec_halt) begin
                    if (bus.i_irq_pending) begin
                        end_instr = 1'b1;
`ifdef SM83_HALT_BUG_EN
                        pc_inh_n = ~ime & ~take;
`endif
                    end else begin
                        // HALT entry is where a pending EI takes effect.
                        state_n  = ST_HALT;
                        ime_n    = ime | ei_arm;
                        ei_arm_n = 1'b0;
                    end
                end else if (dec_len != 3'd0) begin
                    state_n = ST_EXEC;
                    idx_n   = 3'd1;
                end else begin
                    end_instr = 1'b1;
                end
            end
            ST_PREFIX: begin
                len_n = dec_len;
                if (dec_len != 3'd0) begin
                    state_n = ST_EXEC;
                    idx_n   = 3'd1;
                end else begin
                    end_instr = 1'b1;
                end
            end
            ST_EXEC: begin
                if (idx >= len || bus.i_cc_fail) end_instr = 1'b1;
                else idx_n = idx + 3'd1;
            end
            ST_HALT: begin
                if (bus.i_irq_pending) begin
                    step_n  = 3'd0;
                    state_n = ime ? ST_ISR : ST_FETCH;
                    ime_n   = 1'b0;
                end
            end
            ST_ISR: begin
                if (step >= ISR_LAST) begin
                    state_n = ST_FETCH;
                    step_n  = 3'd0;
                end else begin
                    step_n = step + 3'd1;
                end
            end
            default: state_n = ST_RST;
        endcase
        if (end_instr) begin
            state_n  = take ? ST_ISR : ST_FETCH;
            ime_n    = di_f ? 1'b0 : (take ? 1'b0 : (ime | ei_arm | reti_f));
            ei_arm_n = ei_f & ~di_f;
            idx_n    = 3'd0;
            step_n   = 3'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RST;
            len       <= 3'd0;
            idx       <= 3'd0;
            step      <= 3'd0;
            ime       <= 1'b0;
            ei_arm    <= 1'b0;
            ei_flag   <= 1'b0;
            di_flag   <= 1'b0;
            reti_flag <= 1'b0;
            pc_inh    <= 1'b0;
        end else if (!bus.i_stall) begin
            state     <= state_n;
            len       <= len_n;
            idx       <= idx_n;
            step      <= step_n;
            ime       <= ime_n;
            ei_arm    <= ei_arm_n;
            ei_flag   <= ei_flag_n;
            di_flag   <= di_flag_n;
            reti_flag <= reti_flag_n;
            pc_inh    <= pc_inh_n;
        end
    end

    assign bus.o_fetch_cycle   = (state == ST_FETCH);
    assign bus.o_prefix_cycle  = (state == ST_PREFIX);
    assign bus.o_execute_cycle = (state == ST_EXEC);
    assign bus.o_exec_idx      = (state == ST_EXEC) ? idx : 3'd0;
    assign bus.o_isr_cycle     = (state == ST_ISR);
    assign bus.o_isr_step      = (state == ST_ISR) ? step : 3'd0;
    assign bus.o_isr_ack       = (state == ST_ISR) && (step == 3'd2) && !bus.i_stall;
    assign bus.o_halted        = (state == ST_HALT);
    assign bus.o_ime           = ime;
    assign bus.o_pc_inhibit    = (state == ST_FETCH) && pc_inh;
    assign bus.state_dbg       = state;

endmodule

// File: tb/tb_sm83_mcycle_seq.sv
// Self-checking bench for sm83_mcycle_seq: instruction-level reference model feeding
// an expected-output queue, randomized instruction streams and stalls.
module tb_sm83_mcycle_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sm83_mcycle_seq_if bus();

    sm83_mcycle_seq #(.MAX_EXEC(6), .ISR_CYCLES(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef SM83_HALT_BUG_EN
    localparam bit BUG = 1'b1;
`else
    localparam bit BUG = 1'b0;
`endif

    typedef struct packed {
        logic       stall;
        logic [2:0] dexec;
        logic       pre, hlt, ei, di, reti, ccf, pend;
    } stim_t;

    stim_t       stim_q[$];
    logic [13:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        m_ime, m_arm, m_pci;

    // Output word: {fetch, prefix, exec, idx[3], isr, step[3], ack, halted, ime, pc_inhibit}
    function automatic logic [13:0] mk(input logic f, p, e, input logic [2:0] idx,
                                       input logic isr, input logic [2:0] step,
                                       input logic ack, h, ime, pci);
        return {f, p, e, idx, isr, step, ack, h, ime, pci};
    endfunction

    function automatic logic [13:0] obs();
        return {bus.o_fetch_cycle, bus.o_prefix_cycle, bus.o_execute_cycle, bus.o_exec_idx,
                bus.o_isr_cycle, bus.o_isr_step, bus.o_isr_ack, bus.o_halted, bus.o_ime,
                bus.o_pc_inhibit};
    endfunction

    function automatic stim_t mkstim(input logic [2:0] dexec, input logic pre, hlt, ei, di,
                                     reti, ccf, pend);
        stim_t s;
        s = {1'b0, dexec, pre, hlt, ei, di, reti, ccf, pend};
        return s;
    endfunction

    function automatic int pick_stall(input bit rnd);
        if (rnd && $urandom_range(0, 7) == 0) return int'($urandom_range(1, 2));
        return 0;
    endfunction

    task automatic drive_idle();
        bus.i_stall = 1'b0; bus.i_dec_exec = 3'd0; bus.i_dec_prefix = 1'b0;
        bus.i_dec_halt = 1'b0; bus.i_dec_ei = 1'b0; bus.i_dec_di = 1'b0;
        bus.i_dec_reti = 1'b0; bus.i_cc_fail = 1'b0; bus.i_irq_pending = 1'b0;
    endtask

    task automatic apply(input stim_t s, output logic [13:0] seen);
        @(negedge clk);
        bus.i_stall = s.stall; bus.i_dec_exec = s.dexec; bus.i_dec_prefix = s.pre;
        bus.i_dec_halt = s.hlt; bus.i_dec_ei = s.ei; bus.i_dec_di = s.di;
        bus.i_dec_reti = s.reti; bus.i_cc_fail = s.ccf; bus.i_irq_pending = s.pend;
        #1;
        seen = obs();
    endtask

    // A stalled cycle repeats the cycle's outputs, with the ack pulse held off.
    task automatic push(input stim_t s, input logic [13:0] e, input int nstall);
        stim_t st;
        st = s;
        st.stall = 1'b1;
        for (int j = 0; j < nstall; j++) begin
            stim_q.push_back(st);
            exp_q.push_back(e & 14'h3ff7);
        end
        s.stall = 1'b0;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic model_isr(input bit rnd);
        for (int s = 0; s < 5; s++)
            push(mkstim(3'($urandom_range(0, 7)), 0, 0, 0, 0, 0, 0, 1'($urandom_range(0, 1))),
                 mk(0, 0, 0, 3'd0, 1, 3'(s), s == 2, 0, 0, 0), pick_stall(rnd));
    endtask

    // One instruction: fetch, optional CB byte, execute cycles, then the boundary rules.
    task automatic model_instr(input int exec, input bit pre, ei, di, reti, input int cc_at,
                               input bit pend, input int stall_idx, input bit rnd);
        int len, n;
        bit take;
        len = (exec > 6) ? 6 : exec;
        n   = (cc_at > 0 && cc_at <= len) ? cc_at : len;
        push(mkstim(pre ? 3'($urandom_range(0, 7)) : 3'(exec), pre, 0, ei, di, reti, 0, pend),
             mk(1, 0, 0, 3'd0, 0, 3'd0, 0, 0, m_ime, m_pci), pick_stall(rnd));
        m_pci = 1'b0;
        if (pre)
            push(mkstim(3'(exec), 0, 0, 0, 0, 0, 0, pend),
                 mk(0, 1, 0, 3'd0, 0, 3'd0, 0, 0, m_ime, 0), pick_stall(rnd));
        for (int i = 1; i <= n; i++)
            push(mkstim(3'($urandom_range(0, 7)), 0, 0, 0, 0, 0, i == cc_at, pend),
                 mk(0, 0, 1, 3'(i), 0, 3'd0, 0, 0, m_ime, 0),
                 (i == stall_idx) ? 2 : pick_stall(rnd));
        take  = (m_ime | m_arm) & pend & ~di;
        m_ime = di ? 1'b0 : (take ? 1'b0 : (m_ime | m_arm | reti));
        m_arm = ei & ~di;
        if (take) model_isr(rnd);
    endtask

    task automatic model_halt(input int wait_n);
        push(mkstim(3'd0, 0, 1, 0, 0, 0, 0, 0), mk(1, 0, 0, 3'd0, 0, 3'd0, 0, 0, m_ime, m_pci), 0);
        m_pci = 1'b0;
        m_ime = m_ime | m_arm;
        m_arm = 1'b0;
        for (int w = 1; w <= wait_n; w++)
            push(mkstim(3'($urandom_range(0, 7)), 0, 0, 0, 0, 0, 0, w == wait_n),
                 mk(0, 0, 0, 3'd0, 0, 3'd0, 0, 1, m_ime, 0), 0);
        if (m_ime) begin
            m_ime = 1'b0;
            model_isr(0);
        end
    endtask

    task automatic model_halt_pending();
        bit take, was_ime;
        push(mkstim(3'd0, 0, 1, 0, 0, 0, 0, 1), mk(1, 0, 0, 3'd0, 0, 3'd0, 0, 0, m_ime, m_pci), 0);
        was_ime = m_ime;
        take    = m_ime | m_arm;
        m_ime   = take ? 1'b0 : (m_ime | m_arm);
        m_arm   = 1'b0;
        m_pci   = BUG & ~was_ime & ~take;
        if (take) model_isr(0);
    endtask

    task automatic model_reset();
        m_ime = 1'b0; m_arm = 1'b0; m_pci = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] seen, want;
        stim_t s;
        drive_idle();
        bus.i_stall = 1'b1;
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if (obs() !== 14'd0) begin
                n_fail++;
                $display("FAIL test_reset held: got %h expected %h", obs(), 14'd0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_stall = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 14'd0) begin
            n_fail++;
            $display("FAIL test_reset release: got %h expected %h", obs(), 14'd0);
        end
        model_reset();
        for (int k = 0; k < 4; k++) model_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); want = exp_q.pop_front(); apply(s, seen);
            n_checks++;
            if (seen !== want) begin
                n_fail++;
                $display("FAIL test_reset fetch: got %h expected %h", seen, want);
            end
        end
    endtask

    task automatic test_exec();
        logic [13:0] seen, want;
        stim_t s;
        model_instr(3, 0, 0, 0, 0, 0, 0, 0, 0);
        model_instr(3, 0, 0, 0, 0, 1, 0, 0, 0);
        model_instr(7, 0, 0, 0, 0, 0, 0, 0, 0);
        model_instr(2, 0, 0, 0, 0, 2, 0, 0, 0);
        model_instr(1, 0, 0, 0, 0, 0, 0, 0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); want = exp_q.pop_front(); apply(s, seen);
            n_checks++;
            if (seen !== want) begin
                n_fail++;
                $display("FAIL test_exec: got %h expected %h", seen, want);
            end
        end
    endtask

    task automatic test_prefix_stall();
        logic [13:0] seen, want;
        stim_t s;
        model_instr(2, 1, 0, 0, 0, 0, 0, 0, 0);
        model_instr(3, 0, 0, 0, 0, 0, 0, 2, 0);
        model_instr(0, 1, 0, 0, 0, 0, 0, 0, 0);
        model_instr(2, 1, 0, 0, 0, 0, 0, 1, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); want = exp_q.pop_front(); apply(s, seen);
            n_checks++;
            if (seen !== want) begin
                n_fail++;
                $display("FAIL test_prefix_stall: got %h expected %h", seen, want);
            end
        end
    endtask

    task automatic test_ime();
        logic [13:0] seen, want;
        stim_t s;
        model_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_instr(0, 0, 1, 0, 0, 0, 1, 0, 0);
        model_instr(0, 0, 0, 0, 0, 0, 1, 0, 0);
        model_instr(0, 0, 0, 0, 0, 0, 1, 0, 0);
        model_instr(0, 0, 1, 0, 0, 0, 0, 0, 0);
        model_instr(0, 0, 0, 1, 0, 0, 0, 0, 0);
        model_instr(0, 0, 0, 0, 0, 0, 1, 0, 0);
        model_instr(2, 0, 0, 0, 1, 0, 0, 0, 0);
        model_instr(1, 0, 0, 0, 0, 0, 1, 0, 0);
        model_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); want = exp_q.pop_front(); apply(s, seen);
            n_checks++;
            if (seen !== want) begin
                n_fail++;
                $display("FAIL test_ime: got %h expected %h", seen, want);
            end
        end
    endtask

    task automatic test_halt();
        logic [13:0] seen, want;
        stim_t s;
        model_instr(0, 0, 0, 1, 0, 0, 0, 0, 0);
        model_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_halt(4);
        model_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_instr(0, 0, 1, 0, 0, 0, 0, 0, 0);
        model_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_halt(4);
        model_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); want = exp_q.pop_front(); apply(s, seen);
            n_checks++;
            if (seen !== want) begin
                n_fail++;
                $display("FAIL test_halt: got %h expected %h", seen, want);
            end
        end
    endtask

    task automatic test_halt_bug();
        logic [13:0] seen, want;
        stim_t s;
        model_instr(0, 0, 0, 1, 0, 0, 0, 0, 0);
        model_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_halt_pending();
        model_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_instr(0, 0, 1, 0, 0, 0, 0, 0, 0);
        model_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_halt_pending();
        model_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); want = exp_q.pop_front(); apply(s, seen);
            n_checks++;
            if (seen !== want) begin
                n_fail++;
                $display("FAIL test_halt_bug: got %h expected %h", seen, want);
            end
        end
    endtask

    task automatic test_random();
        logic [13:0] seen, want;
        stim_t s;
        int r, cc;
        bit pre, ei, di, reti;
        for (int k = 0; k < 80; k++) begin
            r    = int'($urandom_range(0, 15));
            ei   = (r == 0);
            di   = (r == 1);
            reti = (r == 2);
            pre  = (r > 2) && ($urandom_range(0, 5) == 0);
            cc   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            model_instr(int'($urandom_range(0, 7)), pre, ei, di, reti, cc,
                        $urandom_range(0, 3) == 0, 0, 1);
        end
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); want = exp_q.pop_front(); apply(s, seen);
            n_checks++;
            if (seen !== want) begin
                n_fail++;
                $display("FAIL test_random: got %h expected %h", seen, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] seen, want;
        stim_t s;
        model_instr(0, 0, 1, 0, 0, 0, 0, 0, 0);
        model_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_instr(5, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            s = stim_q.pop_front(); want = exp_q.pop_front(); apply(s, seen);
            n_checks++;
            if (seen !== want) begin
                n_fail++;
                $display("FAIL test_reset_mid pre: got %h expected %h", seen, want);
            end
        end
        stim_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if (obs() !== 14'd0) begin
                n_fail++;
                $display("FAIL test_reset_mid held: got %h expected %h", obs(), 14'd0);
            end
        end
        rst_n = 1'b1;
        bus.i_stall = 1'b0;
        model_reset();
        model_instr(1, 0, 0, 0, 0, 0, 1, 0, 0);
        model_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        while (stim_q.size() != 0) begin
            s = stim_q.pop_front(); want = exp_q.pop_front(); apply(s, seen);
            n_checks++;
            if (seen !== want) begin
                n_fail++;
                $display("FAIL test_reset_mid post: got %h expected %h", seen, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exec();
        test_prefix_stall();
        test_ime();
        test_halt();
        test_halt_bug();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
